// File: rtl/sr_latch_harvester_pkg.sv
// trng_pkg: shared types and default constants for the SR-latch entropy harvester.
//   trng_state_e  - trial sequencer states
//   *_DEF         - default values for the harvester parameters
//   sat_inc       - saturating increment for the discard counter
package trng_pkg;

  typedef enum logic [1:0] {
    ST_ARM    = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_HOLD   = 2'd3
  } trng_state_e;

  localparam int ARM_CYC_DEF     = 4;
  localparam int SETTLE_CYC_DEF  = 16;
  localparam int SYNC_STAGES_DEF = 2;
  localparam int WORD_W_DEF      = 8;
  localparam int DISCARD_W       = 16;

  function automatic logic [DISCARD_W-1:0] sat_inc(input logic [DISCARD_W-1:0] v);
    return (&v) ? v : v + {{(DISCARD_W-1){1'b0}}, 1'b1};
  endfunction

endpackage

// File: rtl/sr_latch_harvester_if.sv
// Word hand-off between the harvester and its consumer.
//   word_out        - debiased random word (source -> sink)
//   word_valid_out  - word_out holds a complete word (source -> sink)
//   word_ready_in   - sink accepts the word this cycle (sink -> source)
interface sr_latch_harvester_if
  import trng_pkg::*;
#(
  parameter int WORD_W = WORD_W_DEF
) ();

  logic [WORD_W-1:0] word_out;
  logic              word_valid_out;
  logic              word_ready_in;

  modport master (
    output word_out,
    output word_valid_out,
    input  word_ready_in
  );

  modport slave (
    input  word_out,
    input  word_valid_out,
    output word_ready_in
  );

endinterface

// File: rtl/sr_latch_harvester_sync.sv
// bit_synchronizer: STAGES-deep flop chain bringing an asynchronous bit into
// the clk domain.
//   clk    - destination clock
//   rst_n  - asynchronous active-low reset, clears every stage to 0
//   d      - asynchronous input
//   q      - synchronized output (last stage)
module bit_synchronizer
#(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d};
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/sr_latch_harvester.sv
// sr_latch_harvester: runs repeated force/release trials on a metastable SR
// latch, von Neumann debiases the resolved bits and packs them LSB first into
// words handed out over a valid/ready interface.
//   ref_clk_in       - sole clock
//   rst_n_in         - asynchronous active-low reset
//   latch_q_in       - raw asynchronous latch Q (only the synchronizer sees it)
//   latch_arm_out    - high forces S=R=1, falling edge releases the latch
//   discard_cnt_out  - saturating count of rejected equal pairs
//   word_if          - word_out / word_valid_out / word_ready_in
//
// state     | meaning
// ----------+-------------------------------------------------------------
// ST_ARM    | latch forced (latch_arm_out=1) for ARM_CYC cycles
// ST_SETTLE | latch released, SETTLE_CYC cycles to resolve and synchronize
// ST_SAMPLE | one cycle: take the synchronized bit into the pair logic
// ST_HOLD   | complete word presented, trials paused until it is taken
module sr_latch_harvester
  import trng_pkg::*;
#(
  parameter int ARM_CYC     = ARM_CYC_DEF,
  parameter int SETTLE_CYC  = SETTLE_CYC_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int WORD_W      = WORD_W_DEF
) (
  input  logic                 ref_clk_in,
  input  logic                 rst_n_in,
  input  logic                 latch_q_in,
  output logic                 latch_arm_out,
  output logic [DISCARD_W-1:0] discard_cnt_out,
  sr_latch_harvester_if.master word_if
);

  localparam int TMR_MAX = (ARM_CYC > SETTLE_CYC) ? ARM_CYC : SETTLE_CYC;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);
  localparam int IDX_W   = (WORD_W > 1) ? $clog2(WORD_W) : 1;

  localparam logic [TMR_W-1:0] ARM_LOAD    = TMR_W'(ARM_CYC - 1);
  localparam logic [TMR_W-1:0] SETTLE_LOAD = TMR_W'(SETTLE_CYC - 1);
  // The arm output is registered, so it only rises on the first edge after
  // reset release; one extra timer count keeps that first ARM at ARM_CYC.
  localparam logic [TMR_W-1:0] ARM_FIRST   = TMR_W'(ARM_CYC);
  localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(WORD_W - 1);

  trng_state_e          state_q, state_d;
  logic [TMR_W-1:0]     tmr_q, tmr_d;
  logic                 tmr_zero;
  logic                 arm_q;
  logic                 q_sync;
  logic                 have_q;
  logic                 first_q;
  logic [IDX_W-1:0]     idx_q;
  logic [WORD_W-1:0]    word_q;
  logic [DISCARD_W-1:0] discard_q;

  logic sample_en, pair_close, bit_accept, pair_reject, word_done, xfer;

  bit_synchronizer #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk   (ref_clk_in),
    .rst_n (rst_n_in),
    .d     (latch_q_in),
    .q     (q_sync)
  );

  assign tmr_zero    = (tmr_q == '0);
  assign sample_en   = (state_q == ST_SAMPLE);
  assign pair_close  = sample_en & have_q;
  assign bit_accept  = pair_close & (first_q != q_sync);
  assign pair_reject = pair_close & (first_q == q_sync);
  assign word_done   = bit_accept & (idx_q == LAST_IDX);
  assign xfer        = (state_q == ST_HOLD) & word_if.word_ready_in;

  always_ff @(posedge ref_clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q <= ST_ARM;
      tmr_q   <= ARM_FIRST;
      arm_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      // Registered so the analog latch never sees a decode glitch.
      arm_q   <= (state_d == ST_ARM);
    end
  end

  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    case (state_q)
      ST_ARM: begin
        if (tmr_zero) begin
          state_d = ST_SETTLE;
          tmr_d   = SETTLE_LOAD;
        end else begin
          tmr_d = tmr_q - TMR_W'(1);
        end
      end
      ST_SETTLE: begin
        if (tmr_zero) begin
          state_d = ST_SAMPLE;
        end else begin
          tmr_d = tmr_q - TMR_W'(1);
        end
      end
      ST_SAMPLE: begin
        if (word_done) begin
          state_d = ST_HOLD;
        end else begin
          state_d = ST_ARM;
          tmr_d   = ARM_LOAD;
        end
      end
      ST_HOLD: begin
        if (word_if.word_ready_in) begin
          state_d = ST_ARM;
          tmr_d   = ARM_LOAD;
        end
      end
      default: begin
        state_d = ST_ARM;
        tmr_d   = ARM_LOAD;
      end
    endcase
  end

  always_ff @(posedge ref_clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      have_q    <= 1'b0;
      first_q   <= 1'b0;
      idx_q     <= '0;
      word_q    <= '0;
      discard_q <= '0;
    end else begin
      if (xfer) begin
        have_q <= 1'b0;
        idx_q  <= '0;
      end else if (sample_en) begin
        have_q <= ~have_q;
        if (!have_q) begin
          first_q <= q_sync;
        end
        // (0,1) yields 0 and (1,0) yields 1: the accepted bit is the first.
        if (bit_accept) begin
          word_q[idx_q] <= first_q;
          idx_q         <= word_done ? '0 : idx_q + IDX_W'(1);
        end
      end
      if (pair_reject) begin
        discard_q <= sat_inc(discard_q);
      end
    end
  end

  assign latch_arm_out          = arm_q;
  assign discard_cnt_out        = discard_q;
  assign word_if.word_out       = word_q;
  assign word_if.word_valid_out = (state_q == ST_HOLD);

endmodule

// File: doc/sr_latch_harvester.md
SR_LATCH_HARVESTER -- requirements
Module: sr_latch_harvester

Interface
REQ-001 Parameter ARM_CYC, default 4: cycles the latch is held in the forced (S=R=1) state per trial.
REQ-002 Parameter SETTLE_CYC, default 16: cycles allowed for the latch to resolve before sampling; SHALL be >= SYNC_STAGES+1.
REQ-003 Parameter SYNC_STAGES, default 2: flops in the input synchronizer chain, minimum 2.
REQ-004 Parameter WORD_W, default 8: bits per output word.
REQ-005 ref_clk_in  input  1  sole clock; all state SHALL be on its rising edge.
REQ-006 rst_n_in  input  1  reset, asynchronous assert, active-low.
REQ-007 latch_q_in  input  1  raw, asynchronous Q of the metastable SR latch.
REQ-008 latch_arm_out  output  1  high forces the latch to S=R=1; falling edge releases it to resolve.
REQ-009 word_out  output  WORD_W  debiased random word.
REQ-010 word_valid_out  output  1  word_out holds a complete word.
REQ-011 word_ready_in  input  1  consumer accepts word_out when high together with word_valid_out.
REQ-012 discard_cnt_out  output  16  saturating count of rejected (equal) bit pairs.

Function
REQ-013 latch_q_in SHALL pass through SYNC_STAGES flops before any use; no other logic SHALL sample it.
REQ-014 FSM states: ARM, SETTLE, SAMPLE, HOLD.
REQ-015 ARM: latch_arm_out=1 for exactly ARM_CYC cycles, then SETTLE.
REQ-016 SETTLE: latch_arm_out=0 for exactly SETTLE_CYC cycles, then SAMPLE.
REQ-017 SAMPLE (one cycle): capture the synchronized bit; latch_arm_out=0; next state ARM, or HOLD if the word just became complete.
REQ-018 Samples SHALL be consumed in pairs (first, second) by von Neumann debiasing: (0,1) accepts 0; (1,0) accepts 1; (0,0)/(1,1) accepts nothing and increments discard_cnt_out.
REQ-019 discard_cnt_out SHALL saturate at 16'hFFFF and never wrap.
REQ-020 Accepted bits SHALL be written LSB first: first accepted bit of a word lands in word_out[0], the WORD_W-th in word_out[WORD_W-1].
REQ-021 The WORD_W-th accepted bit SHALL cause transition to HOLD with word_valid_out=1 on the next cycle.
REQ-022 HOLD: latch_arm_out=0, word_out and word_valid_out stable; no trials run while the word is unaccepted.
REQ-023 Transfer occurs on a cycle with word_valid_out and word_ready_in both high; the next cycle word_valid_out=0, the bit index and pair state are cleared, and the state is ARM.
REQ-024 word_ready_in SHALL be ignored outside HOLD; it may be high continuously.
REQ-025 word_out SHALL be considered undefined while word_valid_out=0 but SHALL NOT change during HOLD.
REQ-026 Trial period with no backpressure SHALL be ARM_CYC+SETTLE_CYC+1 cycles.

Reset
REQ-027 While rst_n_in=0: latch_arm_out=0, word_valid_out=0, word_out=0, discard_cnt_out=0, synchronizer flops=0, pair state empty, bit index 0.
REQ-028 First state after rst_n_in deasserts SHALL be ARM; reset mid-trial or mid-HOLD SHALL discard all partial/pending data.

Structure
REQ-029 Package trng_pkg SHALL hold the FSM state enum and the default parameter constants.
REQ-030 The synchronizer SHALL be a separate sub-module bit_synchronizer (parameter STAGES, reset value 0).
REQ-031 Implementation SHALL be purely synchronous to ref_clk_in apart from the asynchronous reset.

Verification
REQ-032 Timing: defaults, latch_q_in=0 -> latch_arm_out high exactly 4 cycles, low 17, period 21 cycles, repeating.
REQ-033 Stuck bit: latch_q_in=1 constantly for 20 trials -> word_valid_out never rises, discard_cnt_out=10.
REQ-034 Pattern: samples alternate 1,0 for 16 trials, word_ready_in=1 -> one word 8'hFF; samples alternate 0,1 -> 8'h00; pairs (1,0),(0,1) alternating -> 8'h55.
REQ-035 Backpressure: word completes, word_ready_in=0 for 50 cycles -> word_out stable, latch_arm_out=0 throughout; ready high -> valid drops next cycle, ARM follows.
REQ-036 Reset in HOLD: rst_n_in low for 1 cycle -> word_valid_out and latch_arm_out low immediately, discard_cnt_out=0; ARM after release.
REQ-037 Saturation (DUT with counter preloaded by force to 16'hFFFE): 3 equal pairs -> discard_cnt_out=16'hFFFF.
